load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Parametrised load/store unit between the core datapath and the data-memory bus. It replaces the single-cycle, always-ready memory path with a ready-handshaked, multi-cycle access. It generates byte strobes, aligns store data, and sign/zero-extends load data. It also detects misaligned or illegal accesses and bus timeouts, and holds a stall to the core until each access completes.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
TIMEOUT, 255, max cycles waiting for bus_ready before abort; >=1, counter width $clog2(TIMEOUT+1).

Ports:
clk  in  1  clock.
reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
req_valid  in  1  core presents a load/store; held stable while stall=1.
req_is_store  in  1  1=store, 0=load.
req_funct3  in  3  RISC-V size/sign field (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
req_addr  in  XLEN  effective byte address.
req_wdata  in  XLEN  store data in rs2, LSB-justified.
stall  out  1  core must hold PC and request.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
bus_addr  out  XLEN  request address aligned down to XLEN/8 bytes.
bus_wdata  out  XLEN  lane-shifted store data.
bus_wstrb  out  XLEN/8  byte enables; all zero on reads.
bus_we  out  1  write request.
bus_re  out  1  read request.
bus_rdata  in  XLEN  read data, valid with bus_ready.
bus_ready  in  1  bus completes the current access this cycle.

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE and timeout counter=0. Every output register is cleared: bus_addr/wdata/wstrb/we/re=0, resp_valid=0, resp_rdata=0, resp_err=00. Reset mid-transaction abandons the access and no resp_valid is issued.
- States: IDLE, BUS, RESP.
- IDLE with req_valid=1: the unit latches addr, funct3, is_store, and the low-lane offset off = addr[$clog2(XLEN/8)-1:0].
  - Illegal size goes to RESP with err=11. Illegal means funct3 111; 011 or 110 when XLEN=32; or 011/110/111 with store for 1xx.
  - Otherwise misaligned goes to RESP with err=01. Misaligned means H with off[0]!=0, W with off[1:0]!=0, or D with off[2:0]!=0.
  - Otherwise the unit goes to BUS with registered bus outputs valid the next cycle.
- stall is combinational. It equals (state==IDLE & req_valid) | (state==BUS), and it is 0 in RESP.
- BUS: bus_re or bus_we stays high with stable addr/wdata/wstrb until bus_ready=1.
  - wstrb = size mask (B 0x1, H 0x3, W 0xF, D 0xFF) << off.
  - wdata = req_wdata << (8*off).
  - On bus_ready: go to RESP. For loads, capture (bus_rdata >> 8*off), then sign-extend (B/H/W) or zero-extend (BU/HU/WU) from the access size.
  - bus_re/we drop in the cycle after bus_ready.
- Timeout counter increments each BUS cycle without bus_ready. When it reaches TIMEOUT, the unit goes to RESP with err=10 and rdata=0, and bus_re/we drop. If bus_ready arrives on the same cycle as the limit, bus_ready wins and no error is raised.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_err valid. The unit then returns to IDLE unconditionally. req_valid in the RESP cycle is ignored because it still belongs to the completing instruction. A new request can be accepted the cycle after RESP.
- Latency: a request accepted at cycle N with bus_ready at the first BUS cycle gives resp_valid at N+2 and stall high for cycles N and N+1. Error paths give resp_valid at N+1.
- Stores report resp_rdata=0. Errors never drive bus_re/we.

Test Plan:
- Reset: hold reset_n=0 with req_valid=1 -> all outputs 0, stall=1 only combinationally, no bus_re/we; release -> access proceeds normally.
- LB, XLEN=32: addr=0x1003, bus_rdata=0x80FF_0000, bus_ready on first BUS cycle -> bus_addr=0x1000, resp_rdata=0xFFFF_FF80, err=00, resp_valid 2 cycles after accept. Same access as LBU -> 0x0000_0080.
- SH: addr=0x2002, wdata=0x1234_ABCD -> bus_wstrb=0xC, bus_wdata=0xABCD_0000, bus_we held through 3 wait cycles, stall high throughout, resp_valid after ready.
- Misaligned and illegal: LW at 0x3001 -> err=01 one cycle after accept with no bus activity. funct3=011 at XLEN=32 -> err=11.
- Timeout: TIMEOUT=4, LW with bus_ready held 0 -> err=10, rdata=0, bus_re deasserted. Rerun with bus_ready on the 4th wait cycle -> err=00.
- XLEN=64: LWU at 0x...04 with bus_rdata=0xF000_0000_0000_0000 -> rdata=0x0000_0000_F000_0000. SD at 0x8 -> wstrb=0xFF. Back-to-back loads are accepted in the cycle after RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - ready-handshaked load/store unit with lane alignment, extension and bus timeout
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_ready
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, next_state;

    logic [2:0]      funct3_q;
    logic            is_store_q;
    logic [OFFW-1:0] off_q;
    logic [CW-1:0]   tcnt;

    logic [OFFW-1:0] req_off;
    logic [2:0]      off3;
    logic            illegal, misaligned, timeout_hit;
    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] lane_rdata, ext_rdata;

    assign req_off = req_addr[OFFW-1:0];
    assign off3    = 3'(req_off);

    // Doubleword and WU only exist on 64-bit cores; unsigned sizes are load-only.
    assign illegal = (req_funct3 == 3'b111)
                  || ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
                  || (req_is_store && req_funct3[2]);

    always_comb begin
        misaligned = 1'b0;
        size_mask  = NB'(8'h01);
        case (req_funct3[1:0])
            2'b01: begin misaligned = off3[0];       size_mask = NB'(8'h03); end
            2'b10: begin misaligned = |off3[1:0];    size_mask = NB'(8'h0F); end
            2'b11: begin misaligned = |off3;         size_mask = NB'(8'hFF); end
            default: ;
        endcase
    end

    // Bus_ready on the limit cycle takes priority over the abort.
    assign timeout_hit = (state == BUS) && !bus_ready && (tcnt == CW'(TIMEOUT - 1));

    assign lane_rdata = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_rdata = lane_rdata;
        case (funct3_q)
            3'b000:  ext_rdata = XLEN'($signed(lane_rdata[7:0]));
            3'b001:  ext_rdata = XLEN'($signed(lane_rdata[15:0]));
            3'b010:  ext_rdata = XLEN'($signed(lane_rdata[31:0]));
            3'b100:  ext_rdata = XLEN'(lane_rdata[7:0]);
            3'b101:  ext_rdata = XLEN'(lane_rdata[15:0]);
            3'b110:  ext_rdata = XLEN'(lane_rdata[31:0]);
            default: ext_rdata = lane_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (illegal || misaligned) ? RESP : BUS;
            BUS:     if (bus_ready || timeout_hit) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall = ((state == IDLE) && req_valid) || (state == BUS);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            off_q      <= '0;
            tcnt       <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            bus_we     <= 1'b0;
            bus_re     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    funct3_q   <= req_funct3;
                    is_store_q <= req_is_store;
                    off_q      <= req_off;
                    tcnt       <= '0;
                    if (illegal || misaligned) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= illegal ? 2'b11 : 2'b01;
                    end else begin
                        bus_addr  <= {req_addr[XLEN-1:OFFW], OFFW'(0)};
                        bus_wdata <= req_wdata << {req_off, 3'b000};
                        bus_wstrb <= req_is_store ? (size_mask << req_off) : '0;
                        bus_we    <= req_is_store;
                        bus_re    <= !req_is_store;
                    end
                end
                BUS: begin
                    if (bus_ready || timeout_hit) begin
                        bus_we     <= 1'b0;
                        bus_re     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= bus_ready ? 2'b00 : 2'b10;
                        resp_rdata <= (bus_ready && !is_store_q) ? ext_rdata : '0;
                    end
                    if (!bus_ready) tcnt <= tcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
